// File: rtl/rs485_pkg.sv
// Shared RS-485 link constants and types for the receiver, the baud divider
// and the future transmitter.
package rs485_pkg;

  localparam int unsigned BIT_CYCLES_DEF  = 32'd2606;
  localparam int unsigned HALF_CYCLES_DEF = BIT_CYCLES_DEF / 32'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Returns 1 when data plus parity bit holds an odd number of ones (even-parity violation).
  function automatic logic parity_bad(input logic [7:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction

endpackage

// File: rtl/rs485_sync.sv
// Two-flop synchronizer for asynchronous line inputs; reset value is selectable
// so idle-high and idle-low sense lines both come out of reset quietly.
module rs485_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk25,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Metastability chain: meta_r settles, q is the usable synchronous copy.
  always_ff @(posedge clk25) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/rs485_uart_rx.sv
// RS-485 UART receiver: 8 data bits LSB-first, optional even parity, one stop
// bit, delivered over a valid/ready handshake with framing/parity/overrun flags.
module rs485_uart_rx
  import rs485_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int unsigned HALF_CYCLES = HALF_CYCLES_DEF,
  parameter int unsigned PARITY_EN   = 32'd0
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int unsigned    CW        = (BIT_CYCLES > 32'd1) ? $clog2(BIT_CYCLES) : 32'd1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYCLES - 32'd1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_CYCLES - 32'd1);
  localparam bit             PAR_ON    = (PARITY_EN != 32'd0);

  logic          rxd_s;
  logic          rxd_prev_r;
  rx_state_t     state_r;
  logic [CW-1:0] cyc_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic          done_r;
  logic          bit_end_s;
  logic          par_bad_s;

  rs485_sync #(.RST_VAL(1'b1)) u_sync (
    .clk25 (clk25),
    .rst   (rst),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign bit_end_s = (cyc_cnt_r == BIT_LAST);
  assign par_bad_s = PAR_ON && parity_bad(shift_r, par_r);

  // Frame FSM plus the delivery stage one cycle behind the stop sample.
  always_ff @(posedge clk25) begin
    if (rst) begin
      rxd_prev_r  <= 1'b1;
      state_r     <= IDLE;
      cyc_cnt_r   <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_r       <= 1'b0;
      done_r      <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rxd_prev_r  <= rxd_s;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      done_r      <= 1'b0;

      // shift_r cannot change within a cycle of the stop sample, so it doubles as the holding source.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done_r) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (rxd_prev_r && !rxd_s) begin
            state_r   <= START;
            cyc_cnt_r <= '0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (cyc_cnt_r == HALF_LAST) begin
            cyc_cnt_r <= '0;
            if (!rxd_s) begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cyc_cnt_r <= '0;
            shift_r   <= {rxd_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) state_r <= PAR_ON ? PARITY : STOP;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            cyc_cnt_r <= '0;
            par_r     <= rxd_s;
            state_r   <= STOP;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            cyc_cnt_r  <= '0;
            state_r    <= IDLE;
            busy       <= 1'b0;
            frame_err  <= !rxd_s;
            parity_err <= par_bad_s;
            done_r     <= rxd_s && !par_bad_s;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cyc_cnt_r <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
